// File: rtl/sound_ctrl.sv
// Speaker scheduler for the digital clock: alarm/snooze sequencer plus chime and key-click arbitration.
// Optional hourly chime requester is built only when SOUND_CHIME_EN is defined.
module sound_ctrl #(
    parameter int unsigned RING_MAX   = 60,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter int unsigned CLICK_MS   = 20
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic [7:0] Hour,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    input  logic [7:0] Set_Hr,
    input  logic [7:0] Set_Min,
    input  logic       CtrlBell,
    input  logic       SnoozeKey,
    input  logic       StopKey,
    input  logic       AnyKey,
    output logic       Speaker,
    output logic       AlarmActive,
    output logic       SnoozeActive,
    output logic [1:0] SnoozeCnt
);

    localparam int unsigned RING_W  = 7;
    localparam int unsigned SNZ_W   = 4;
    localparam int unsigned CLICK_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [RING_W-1:0]    ring_sec, ring_nxt;
    logic [SNZ_W-1:0]     snz_min, snz_nxt;
    logic [1:0]           cnt_nxt;
    logic [2:0]           snz_sync, stop_sync, any_sync;
    logic [7:0]           sec_prev;
    logic [1:0]           tone_cnt;
    logic [CLICK_W-1:0]   click_cnt;
    logic                 snz_ev, stop_ev, any_ev;
    logic                 sec_tick, min_tick, match;
    logic                 tone_hi, tone_lo;
    logic                 chime_req, chime_tone, spk_nxt;

    // Keys: [0],[1] synchroniser, [2] previous value for falling-edge detect
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            snz_sync  <= 3'b111;
            stop_sync <= 3'b111;
            any_sync  <= 3'b111;
            sec_prev  <= 8'h00;
            tone_cnt  <= 2'd0;
        end else begin
            snz_sync  <= {snz_sync[1:0], SnoozeKey};
            stop_sync <= {stop_sync[1:0], StopKey};
            any_sync  <= {any_sync[1:0], AnyKey};
            sec_prev  <= Second;
            tone_cnt  <= tone_cnt + 2'd1;
        end
    end

    assign snz_ev   = snz_sync[2] & ~snz_sync[1];
    assign stop_ev  = stop_sync[2] & ~stop_sync[1];
    assign any_ev   = any_sync[2] & ~any_sync[1];
    assign sec_tick = (Second != sec_prev);
    assign min_tick = sec_tick && (Second == 8'h00);
    assign match    = (Hour == Set_Hr) && (Minute == Set_Min) && (Second == 8'h00);
    assign tone_hi  = tone_cnt[0];
    assign tone_lo  = tone_cnt[1];

    // Alarm sequencer next state; CtrlBell low dominates every transition
    always_comb begin
        state_nxt = state;
        ring_nxt  = ring_sec;
        snz_nxt   = snz_min;
        cnt_nxt   = SnoozeCnt;
        if (!CtrlBell) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state_nxt = RINGING;
                        ring_nxt  = '0;
                        cnt_nxt   = 2'd0;
                    end
                end
                RINGING: begin
                    if (stop_ev) begin
                        state_nxt = DONE;
                    end else if (snz_ev && (32'(SnoozeCnt) < MAX_SNOOZE)) begin
                        state_nxt = SNOOZE;
                        cnt_nxt   = SnoozeCnt + 2'd1;
                        snz_nxt   = '0;
                    end else if (sec_tick) begin
                        if (ring_sec == RING_W'(RING_MAX - 1)) begin
                            state_nxt = DONE;
                        end else begin
                            ring_nxt = ring_sec + RING_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_ev) begin
                        state_nxt = DONE;
                    end else if (min_tick) begin
                        if (snz_min == SNZ_W'(SNOOZE_MIN - 1)) begin
                            state_nxt = RINGING;
                            ring_nxt  = '0;
                        end else begin
                            snz_nxt = snz_min + SNZ_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Hold until the alarm minute has passed so it cannot retrigger
                    if (Minute != Set_Min) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state        <= IDLE;
            ring_sec     <= '0;
            snz_min      <= '0;
            SnoozeCnt    <= 2'd0;
            AlarmActive  <= 1'b0;
            SnoozeActive <= 1'b0;
        end else begin
            state        <= state_nxt;
            ring_sec     <= ring_nxt;
            snz_min      <= snz_nxt;
            SnoozeCnt    <= cnt_nxt;
            AlarmActive  <= (state_nxt == RINGING);
            SnoozeActive <= (state_nxt == SNOOZE);
        end
    end

    // Click burst: any press (re)loads, then counts down to silence
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            click_cnt <= '0;
        end else if (any_ev) begin
            click_cnt <= CLICK_W'(CLICK_MS);
        end else if (click_cnt != '0) begin
            click_cnt <= click_cnt - CLICK_W'(1);
        end
    end

`ifdef SOUND_CHIME_EN
    always_comb begin
        chime_req  = 1'b0;
        chime_tone = 1'b0;
        if (Minute == 8'h59) begin
            case (Second)
                8'h51, 8'h53, 8'h55, 8'h57: begin
                    chime_req  = 1'b1;
                    chime_tone = tone_lo;
                end
                8'h59: begin
                    chime_req  = 1'b1;
                    chime_tone = tone_hi;
                end
                default: ;
            endcase
        end
    end
`else
    assign chime_req  = 1'b0;
    assign chime_tone = 1'b0;
`endif

    // Fixed priority: ringing alarm, then chime, then click
    always_comb begin
        spk_nxt = 1'b0;
        if (state == RINGING) begin
            spk_nxt = Second[0] ? tone_lo : tone_hi;
        end else if (chime_req) begin
            spk_nxt = chime_tone;
        end else if (click_cnt != '0) begin
            spk_nxt = tone_hi;
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            Speaker <= 1'b0;
        end else begin
            Speaker <= spk_nxt;
        end
    end

endmodule

// File: tb/tb_sound_ctrl.sv
// Randomised bench for sound_ctrl against a time-line reference model (counts of edges, seconds and minutes).
module tb_sound_ctrl;

    localparam int RING_MAX   = 60;
    localparam int SNOOZE_MIN = 5;
    localparam int MAX_SNOOZE = 3;
    localparam int CLICK_MS   = 20;
`ifdef SOUND_CHIME_EN
    localparam bit CHIME_EN = 1'b1;
`else
    localparam bit CHIME_EN = 1'b0;
`endif

    localparam int M_IDLE = 10, M_RING = 11, M_SNZ = 12, M_DONE = 13;

    logic       CP = 1'b0;
    logic       nCR = 1'b0;
    logic       CtrlBell = 1'b0;
    logic       snz_k = 1'b1, stop_k = 1'b1, oth_k = 1'b1;
    logic [7:0] Hour, Minute, Second, Set_Hr, Set_Min;
    logic       SnoozeKey, StopKey, AnyKey;
    logic       Speaker, AlarmActive, SnoozeActive;
    logic [1:0] SnoozeCnt;

    int hh = 0, mm = 0, ss = 0, ah = 12, am = 0;
    int n_checks = 0, n_fail = 0;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    assign Hour      = bcd(hh);
    assign Minute    = bcd(mm);
    assign Second    = bcd(ss);
    assign Set_Hr    = bcd(ah);
    assign Set_Min   = bcd(am);
    assign SnoozeKey = snz_k;
    assign StopKey   = stop_k;
    assign AnyKey    = snz_k & stop_k & oth_k;

    sound_ctrl #(
        .RING_MAX(RING_MAX), .SNOOZE_MIN(SNOOZE_MIN),
        .MAX_SNOOZE(MAX_SNOOZE), .CLICK_MS(CLICK_MS)
    ) dut (
        .CP(CP), .nCR(nCR), .Hour(Hour), .Minute(Minute), .Second(Second),
        .Set_Hr(Set_Hr), .Set_Min(Set_Min), .CtrlBell(CtrlBell),
        .SnoozeKey(SnoozeKey), .StopKey(StopKey), .AnyKey(AnyKey),
        .Speaker(Speaker), .AlarmActive(AlarmActive),
        .SnoozeActive(SnoozeActive), .SnoozeCnt(SnoozeCnt)
    );

    always #5 CP = ~CP;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0d:%0d:%0d t=%0t", tag, obs, exp, hh, mm, ss, $time);
        end
    endtask

    // Reference model: edge index, running second/minute tick totals and deadlines
    int       m_mode, m_scnt, m_spk;
    int       n_edge, last_click, sec_total, min_total, ring_end, snz_end, sec_prev;
    bit [2:0] h_snz, h_stop, h_any;

    task automatic model_reset();
        m_mode = M_IDLE; m_scnt = 0; m_spk = 0;
        n_edge = 0; last_click = -1000; sec_total = 0; min_total = 0;
        ring_end = 0; snz_end = 0; sec_prev = 0;
        h_snz = 3'b111; h_stop = 3'b111; h_any = 3'b111;
    endtask

    task automatic model_step();
        bit stop_ev, snz_ev, any_ev, st, mt, lo, hi;
        bit [1:0] ph;
        // a press is acted on three edges after it is first sampled
        stop_ev = h_stop[2] && !h_stop[1];
        snz_ev  = h_snz[2] && !h_snz[1];
        any_ev  = h_any[2] && !h_any[1];
        ph = 2'(n_edge);
        hi = ph[0];
        lo = ph[1];

        if (m_mode == M_RING)                                           m_spk = (ss % 2 == 1) ? lo : hi;
        else if (CHIME_EN && mm == 59 && ss >= 51 && ss <= 57 && ss % 2 == 1) m_spk = lo;
        else if (CHIME_EN && mm == 59 && ss == 59)                      m_spk = hi;
        else if (n_edge - last_click >= 1 && n_edge - last_click <= CLICK_MS) m_spk = hi;
        else                                                            m_spk = 0;

        st = (ss != sec_prev);
        sec_prev = ss;
        mt = st && (ss == 0);
        if (st) sec_total++;
        if (mt) min_total++;

        if (!CtrlBell) m_mode = M_IDLE;
        else if (m_mode == M_IDLE) begin
            if (hh == ah && mm == am && ss == 0) begin
                m_mode = M_RING; m_scnt = 0; ring_end = sec_total + RING_MAX;
            end
        end else if (m_mode == M_RING) begin
            if (stop_ev) m_mode = M_DONE;
            else if (snz_ev && m_scnt < MAX_SNOOZE) begin
                m_mode = M_SNZ; m_scnt++; snz_end = min_total + SNOOZE_MIN;
            end else if (st && sec_total == ring_end) m_mode = M_DONE;
        end else if (m_mode == M_SNZ) begin
            if (stop_ev) m_mode = M_DONE;
            else if (mt && min_total == snz_end) begin
                m_mode = M_RING; ring_end = sec_total + RING_MAX;
            end
        end else if (m_mode == M_DONE) begin
            if (mm != am) m_mode = M_IDLE;
        end

        if (any_ev) last_click = n_edge;
        h_stop = {h_stop[1:0], stop_k};
        h_snz  = {h_snz[1:0], snz_k};
        h_any  = {h_any[1:0], AnyKey};
        n_edge++;
    endtask

    task automatic tick();
        @(posedge CP);
        if (!nCR) model_reset();
        else model_step();
        @(negedge CP);
        check("speaker", int'(Speaker), m_spk);
        check("alarm_active", int'(AlarmActive), int'(m_mode == M_RING));
        check("snooze_active", int'(SnoozeActive), int'(m_mode == M_SNZ));
        check("snooze_cnt", int'(SnoozeCnt), m_scnt);
    endtask

    task automatic adv_sec(input int k);
        repeat (k) begin
            ss++;
            if (ss == 60) begin
                ss = 0; mm++;
                if (mm == 60) begin mm = 0; hh = (hh + 1) % 24; end
            end
            repeat ($urandom_range(3, 6)) tick();
        end
    endtask

    task automatic jump_min();
        ss = 59;
        tick(); tick();
        adv_sec(1);
    endtask

    task automatic press(input int which);
        if (which == 0) stop_k = 1'b0;
        else if (which == 1) snz_k = 1'b0;
        else oth_k = 1'b0;
        repeat (3) tick();
        stop_k = 1'b1; snz_k = 1'b1; oth_k = 1'b1;
        repeat (2) tick();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hh = h; mm = m; ss = s;
    endtask

    initial begin
        int r;
        model_reset();
        // Reset held while keys chatter
        repeat (8) begin
            snz_k = 1'($urandom); stop_k = 1'($urandom); oth_k = 1'($urandom);
            tick();
        end
        snz_k = 1'b1; stop_k = 1'b1; oth_k = 1'b1;
        nCR = 1'b1;
        repeat (4) tick();
        check("idle_after_reset", int'(AlarmActive), 0);

        // Alarm then stop, no retrigger inside the alarm minute
        CtrlBell = 1'b1; ah = 7; am = 30;
        set_time(7, 29, 58);
        adv_sec(2);
        check("ring_start", int'(AlarmActive), 1);
        adv_sec(2);
        press(0);
        check("stopped", int'(AlarmActive), 0);
        adv_sec(60);
        check("no_retrigger", int'(AlarmActive), 0);

        // Snooze limit and final timeout
        ah = 6; am = 0;
        set_time(5, 59, 58);
        adv_sec(2);
        for (int i = 0; i <= MAX_SNOOZE; i++) begin
            adv_sec(2);
            press(1);
            if (i < MAX_SNOOZE) begin
                check("snoozing", int'(SnoozeActive), 1);
                check("snooze_count", int'(SnoozeCnt), i + 1);
                repeat (SNOOZE_MIN) jump_min();
                check("rering", int'(AlarmActive), 1);
            end else begin
                check("snooze_ignored", int'(AlarmActive), 1);
            end
        end
        adv_sec(RING_MAX + 2);
        check("timeout", int'(AlarmActive), 0);
        check("timeout_quiet", int'(Speaker), 0);

        // Chime with click, then alarm ringing over the chime
        ah = 12; am = 0;
        set_time(8, 59, 49);
        adv_sec(3);
        press(2);
        adv_sec(9);
        ah = 8; am = 59;
        set_time(8, 58, 58);
        adv_sec(57);
        check("ring_over_chime", int'(AlarmActive), 1);
        adv_sec(8);

        // Snooze across midnight, then CtrlBell drop during snooze
        ah = 23; am = 58;
        set_time(23, 57, 59);
        adv_sec(1);
        adv_sec(1);
        press(1);
        repeat (SNOOZE_MIN) jump_min();
        check("midnight_rering", int'(AlarmActive), 1);
        press(1);
        check("snooze_again", int'(SnoozeActive), 1);
        CtrlBell = 1'b0;
        tick();
        check("bell_off", int'(SnoozeActive), 0);
        CtrlBell = 1'b1;
        adv_sec(3);

        // Asynchronous reset in the middle of ringing
        ah = 10; am = 0;
        set_time(9, 59, 59);
        adv_sec(2);
        nCR = 1'b0;
        #1;
        model_reset();
        check("reset_speaker", int'(Speaker), 0);
        check("reset_alarm", int'(AlarmActive), 0);
        repeat (3) tick();
        nCR = 1'b1;
        adv_sec(3);

        // Random mix of time flow, keys, bell and alarm settings
        ah = hh; am = (mm + 1) % 60;
        for (int it = 0; it < 250; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) adv_sec(int'($urandom_range(1, 3)));
            else if (r < 63) press(0);
            else if (r < 71) press(1);
            else if (r < 79) press(2);
            else if (r < 84) jump_min();
            else if (r < 87) begin CtrlBell = ~CtrlBell; tick(); end
            else if (r < 90) set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
            else if (r < 95) begin
                ah = (mm == 59) ? (hh + 1) % 24 : hh;
                am = (mm + 1) % 60;
                CtrlBell = 1'b1;
            end else repeat (int'($urandom_range(1, 8))) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_ctrl.md
Name: sound_ctrl

Overview:
- Single-speaker scheduler for the digital clock. It owns the one Speaker output and shares it between three requesters: the alarm (with snooze), the hourly chime, and the key-click.
- Sequences the alarm through ring, snooze and done states from the BCD time and alarm-set values, and arbitrates all requesters by fixed priority.
- Sits between the timekeeping/alarm-set counters and the speaker pin.

Parameters:
- RING_MAX, 60, maximum ring duration in seconds before automatic stop (1..99)
- SNOOZE_MIN, 5, snooze length in minutes (1..9)
- MAX_SNOOZE, 3, snoozes allowed per alarm event; further SnoozeKey presses are ignored
- CLICK_MS, 20, key-click burst length in CP cycles (1..255)

Ports:
- CP  in  1  system clock, 1 kHz
- nCR  in  1  asynchronous active-low reset
- Hour  in  8  current hour, BCD
- Minute  in  8  current minute, BCD
- Second  in  8  current second, BCD
- Set_Hr  in  8  alarm hour, BCD
- Set_Min  in  8  alarm minute, BCD
- CtrlBell  in  1  alarm enable; 0 forces the FSM to IDLE
- SnoozeKey  in  1  active-low key, debounced externally
- StopKey  in  1  active-low key, debounced externally
- AnyKey  in  1  active-low, OR of all user keys, used for the click
- Speaker  out  1  speaker drive
- AlarmActive  out  1  FSM is in RINGING
- SnoozeActive  out  1  FSM is in SNOOZE
- SnoozeCnt  out  2  snoozes used in the current event

Behaviour:
- One clock domain (CP). Reset is asynchronous, active-low on nCR.
- Reset values: Speaker=0, AlarmActive=0, SnoozeActive=0, SnoozeCnt=0, FSM=IDLE, all counters and synchronisers cleared (keys read as released).
- Key inputs: two-flop synchroniser, then falling-edge detect. Each press gives a one-cycle event.
- sec_tick: registered change of Second (Second != previous Second), one cycle.
- min_tick: sec_tick with Second==8'h00.
- Tones: a free-running 2-bit counter gives tone_hi = bit0 (500 Hz) and tone_lo = bit1 (250 Hz).
- match = (Hour==Set_Hr) && (Minute==Set_Min) && (Second==8'h00).
- FSM states and transitions:
  - IDLE: match && CtrlBell -> RINGING. On entry ring_sec=0, SnoozeCnt=0.
  - RINGING:
    - StopKey event -> DONE.
    - SnoozeKey event with SnoozeCnt<MAX_SNOOZE -> SNOOZE. On this transition SnoozeCnt++ and snz_min=0.
    - ring_sec==RING_MAX-1 on sec_tick -> DONE.
    - ring_sec increments on each sec_tick.
    - If StopKey and SnoozeKey events arrive in the same cycle, Stop wins.
  - SNOOZE:
    - snz_min increments on min_tick.
    - snz_min==SNOOZE_MIN-1 on min_tick -> RINGING, with ring_sec=0.
    - StopKey event -> DONE.
  - DONE: -> IDLE once Minute != Set_Min, so the alarm cannot retrigger within the same minute.
  - Any state: CtrlBell==0 -> IDLE next cycle. This overrides all other transitions.
- Alarm sound while RINGING: tone_lo when Second[0]==1, tone_hi when Second[0]==0.
- Chime request, only when Minute==8'h59:
  - Second in {51,53,55,57}: tone_lo.
  - Second==8'h59: tone_hi.
  - Otherwise silent.
- Click: an AnyKey event loads click_cnt=CLICK_MS. While click_cnt!=0 the click requests tone_hi and click_cnt decrements each cycle. A new press during a burst reloads the counter.
- Arbitration: RINGING alarm > chime > click > 0. A lower-priority requester is masked, not queued; its counters keep running.
- Speaker is registered: one CP of latency from the selected tone.
- Wrap-around: the SNOOZE minute count is independent of hour and day rollover. A snooze spanning 23:59->00:00 completes normally.
- Time jumps (user sets the clock): only exact match triggers. Missed matches are not recovered.
- nCR mid-operation: everything returns to reset values immediately. The sound stops in the same cycle.

Optional Feature:
- Macro: SOUND_CHIME_EN.
- Defined: the hourly chime requester is present, as described above.
- Undefined: chime logic is removed. Speaker carries only the alarm and the click, and there is no output at minute 59 unless one of those is active. Ports are unchanged.

Test Plan:
- Reset: hold nCR=0 with keys toggling -> Speaker=0, AlarmActive=0, SnoozeCnt=0. Release -> state stays IDLE.
- Alarm and stop: Set=07:30, CtrlBell=1, time 07:29:59->07:30:00 -> AlarmActive=1 within 2 CP, Speaker toggles at 500 Hz (even second). StopKey press -> AlarmActive=0. At 07:31:00 -> IDLE, with no retrigger at 07:30:xx.
- Snooze limit: ring, then SnoozeKey -> SnoozeActive=1, SnoozeCnt=1. Advance 5 min_ticks -> RINGING. Repeat to SnoozeCnt=3; a 4th SnoozeKey is ignored, and ringing continues to timeout.
- Auto timeout: ring with no keys for 60 sec_ticks -> DONE on the 60th tick, Speaker=0.
- Chime and priority (SOUND_CHIME_EN defined): time 08:59:51 -> Speaker 250 Hz. At 08:59:59 -> 500 Hz. AnyKey pressed at 08:59:52 -> 20 cycles of 500 Hz click. Same test with alarm set to 08:59 -> chime is masked while RINGING.
- CtrlBell and reset mid-ring: CtrlBell=0 during SNOOZE -> IDLE next cycle, SnoozeActive=0. Also pulse nCR=0 during RINGING -> Speaker=0 in the same cycle.
